result_serializer: RTL and testbench
====================================

# result_serializer

Frames the eigenvalue core's results (regime, kappa, inv_kappa) into a byte stream for the 8-bit output pins. It is the stage directly downstream of the eigenvalue core and sits between the core and the top-level `uo_out` pins. On a one-cycle start pulse it snapshots both 32-bit words and the regime code. It then emits a header byte, the payload bytes MSB-first and a trailer check byte, each under a valid/ready byte handshake.

## Interface

Parameters:
- `SYNC_NIBBLE`, default 4'hA: upper nibble of the header byte.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  tile enable. Low freezes all state and forces outputs idle.
- `start`  in  1  one-cycle pulse: `mode`, `word_a` and `word_b` are valid this cycle.
- `mode`  in  3  regime code from the core. 3'b000 means no valid result.
- `word_a`  in  32  kappa, signed Q16.16, treated as raw bits.
- `word_b`  in  32  inv_kappa, signed Q16.16, treated as raw bits.
- `out_ready`  in  1  host acknowledges the current byte.
- `out_byte`  out  8  current frame byte.
- `out_valid`  out  1  `out_byte` is valid.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse after the trailer handshake.

## Operation

States:
- IDLE: `busy` = 0.
  - On `start` && `ena`: latch `mode`, `word_a`, `word_b`; clear the check accumulator; go to HDR.
- HDR: present header = {`SYNC_NIBBLE`, 1'b0, `mode_q`}.
  - On handshake: if `mode_q` == 0 go to TRAIL; else go to PAY with byte index 0.
- PAY: present byte index 0..7.
  - Index 0..3 are `word_a`[31:24] down to [7:0]; index 4..7 are `word_b`[31:24] down to [7:0].
  - The index advances on each handshake; after index 7, go to TRAIL.
- TRAIL: present the check byte.
  - On handshake: pulse `done` next cycle and return to IDLE.

Rules:
- Handshake is `out_valid` && `out_ready` on a rising edge. A byte must stay stable while `out_valid` is high and `out_ready` is low.
- Check accumulator: updated with every byte at its handshake (header and payload; never the trailer).
- Frame length: 10 bytes normally; 2 bytes when `mode` = 0.
- `start` while `busy` is ignored and the latched data is unchanged.
- `start` with `ena` low is ignored.
- `ena` low mid-frame: state, index and accumulator hold; `out_valid` = 0 and `out_byte` = 0. The frame resumes with the same byte when `ena` returns.
- Reset values: state IDLE, all outputs 0, latches 0, accumulator 0.
- `rst` mid-frame aborts the frame; no `done` is issued.

## Timing

- `start` in cycle N: `out_valid` = 1 with the header in cycle N+1; `busy` = 1 from N+1.
- With `out_ready` held high, one byte per cycle: 10-byte frame occupies cycles N+1 .. N+10.
- `done` = 1 in cycle N+11. `busy` = 0 from N+11.
- A new `start` is accepted in N+11, back-to-back.
- All outputs are registered; there is no combinational path from `out_ready` to `out_byte`.

## Configuration

- `SERIALIZER_CRC8_EN` defined: the check byte is CRC-8.
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - One byte is processed per handshake cycle.
- Not defined: the check byte is the XOR of all header and payload bytes.

## Structure

Shared package `watchdog_pkg` holds:
- the state enum `ser_state_t` (IDLE, HDR, PAY, TRAIL);
- constants `PAYLOAD_BYTES` = 8 and `CRC8_POLY` = 8'h07;
- the function `crc8_byte`.

One sub-module, `result_chk`, holds the check accumulator:
- inputs `clr`, `en`, `din[7:0]`; output `chk[7:0]`;
- the macro selects XOR or CRC-8 inside it.

## Test plan

- Reset: assert `rst` for 3 cycles -> all outputs 0, `busy` 0.
- Full frame, XOR build, `out_ready` = 1: `start`, `mode` = 1, `word_a` = `word_b` = 32'h0001_0000 -> bytes A1 00 01 00 00 00 01 00 00 A1 in cycles N+1..N+10, `done` at N+11.
- Null regime: `mode` = 0 -> frame A0 then A0 in the XOR build, or A0 then 69 with `SERIALIZER_CRC8_EN`.
- Backpressure: drop `out_ready` for 3 cycles at payload index 2 -> `out_byte` stays 01 with `out_valid` high; the frame resumes intact, total length 10.
- Ignored start and `ena` low: pulse `start` with `mode` = 2 mid-frame -> no change to the frame. Drop `ena` for 4 cycles mid-frame -> `out_valid` = 0, then the same byte resumes.
- Reset mid-frame: assert `rst` at payload index 5 -> immediate IDLE, no `done`. A new `start` then produces a complete fresh frame.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared definitions for the result serializer slice.
//   ser_state_t    : frame sequencer states (IDLE, HDR, PAY, TRAIL)
//   PAYLOAD_BYTES  : payload length of a full frame (two 32-bit words)
//   CRC8_POLY      : CRC-8 polynomial x^8 + x^2 + x + 1
//   crc8_byte()    : folds one byte into a CRC-8 (MSB-first, no reflection)
package watchdog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PAY   = 2'd2,
    TRAIL = 2'd3
  } ser_state_t;

  localparam int         PAYLOAD_BYTES = 8;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Byte-stream interface between the serializer and the output pins.
//   out_byte  : current frame byte
//   out_valid : out_byte is valid
//   out_ready : sink accepts the current byte
// Handshake: a byte transfers on a rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready low, the
// source keeps out_byte stable; out_valid never depends on out_ready.
// master = byte source (serializer), slave = byte sink (host).
interface result_serializer_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_byte, output out_valid, input out_ready);
  modport slave  (input out_byte, input out_valid, output out_ready);
endinterface

// File: rtl/result_chk.sv
// Check-byte accumulator for one frame.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart accumulation (frame start)
//   en       : fold din into the accumulator this cycle
//   din      : byte being transferred
//   chk      : current check value
// Build option SERIALIZER_CRC8_EN: defined -> CRC-8 (poly 0x07, init 0x00,
// MSB-first, no reflection, no final XOR); undefined -> running XOR.
module result_chk
  import watchdog_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] chk
);

  logic [7:0] chk_q;
  logic [7:0] chk_d;

  always_comb begin
    chk_d = chk_q;
    if (clr) begin
      chk_d = '0;
    end else if (en) begin
`ifdef SERIALIZER_CRC8_EN
      chk_d = crc8_byte(chk_q, din);
`else
      chk_d = chk_q ^ din;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign chk = chk_q;

endmodule

// File: rtl/result_serializer.sv
// Frames eigenvalue-core results into a byte stream:
//   header {SYNC_NIBBLE, 0, mode}, word_a MSB-first, word_b MSB-first,
//   check byte. A null regime (mode == 0) sends header + check only.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   ena             : tile enable; low freezes state and idles outputs
//   start           : one-cycle pulse, mode/word_a/word_b valid
//   mode, word_a/b  : regime code and the two 32-bit result words
//   bus (master)    : out_byte / out_valid / out_ready byte stream
//   busy, done      : frame in progress / pulse after trailer transfer
//   dbg_state       : sequencer state for observation
// Build option SERIALIZER_CRC8_EN selects a CRC-8 check byte instead of XOR.
module result_serializer
  import watchdog_pkg::*;
#(
  parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       start,
  input  logic [2:0]                 mode,
  input  logic [31:0]                word_a,
  input  logic [31:0]                word_b,
  result_serializer_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output ser_state_t                 dbg_state
);

  ser_state_t  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  mode_q;
  logic [31:0] a_q, b_q;
  logic        done_q;
  logic        hs, accept;
  logic [7:0]  chk;
  logic [7:0]  byte_cur;
  logic [63:0] pay_sh;

  // Frozen tile never transfers; start is only taken from IDLE.
  assign hs     = ena && (state_q != IDLE) && bus.out_ready;
  assign accept = ena && start && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (accept) state_d = HDR;
      HDR: begin
        if (hs) begin
          if (mode_q == 3'd0) begin
            state_d = TRAIL;
          end else begin
            state_d = PAY;
            idx_d   = 3'd0;
          end
        end
      end
      PAY: begin
        if (hs) begin
          if (idx_q == 3'(PAYLOAD_BYTES - 1)) state_d = TRAIL;
          else                                idx_d   = idx_q + 3'd1;
        end
      end
      TRAIL: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= hs && (state_q == TRAIL);
      if (ena) begin
        state_q <= state_d;
        idx_q   <= idx_d;
      end
      if (accept) begin
        mode_q <= mode;
        a_q    <= word_a;
        b_q    <= word_b;
      end
    end
  end

  // Payload byte idx is the top byte of {a, b} shifted left by idx bytes.
  assign pay_sh = {a_q, b_q} << {idx_q, 3'b000};

  // Byte selection uses only registered state, so out_ready never reaches
  // out_byte combinationally.
  always_comb begin
    byte_cur = '0;
    case (state_q)
      HDR:     byte_cur = {SYNC_NIBBLE, 1'b0, mode_q};
      PAY:     byte_cur = pay_sh[63:56];
      TRAIL:   byte_cur = chk;
      default: byte_cur = '0;
    endcase
  end

  result_chk u_chk (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (hs && ((state_q == HDR) || (state_q == PAY))),
    .din (byte_cur),
    .chk (chk)
  );

  // ena only masks the outputs; the held state resumes the same byte.
  assign bus.out_valid = ena && (state_q != IDLE);
  assign bus.out_byte  = ena ? byte_cur : 8'h00;
  assign busy          = ena && (state_q != IDLE);
  assign done          = ena && done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;
  import watchdog_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mode = '0;
  logic [31:0] word_a = '0;
  logic [31:0] word_b = '0;
  logic        busy, done;
  ser_state_t  dbg_state;

  result_serializer_if bus ();

  result_serializer #(.SYNC_NIBBLE(4'hA)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .start     (start),
    .mode      (mode),
    .word_a    (word_a),
    .word_b    (word_b),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected: got %02h, queue empty", bus.out_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out_byte !== e) begin
          errors++;
          $display("FAIL byte_%0d: got %02h, expected %02h", hs_cnt, bus.out_byte, e);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_chk(input logic [7:0] c, input logic [7:0] d);
`ifdef SERIALIZER_CRC8_EN
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
`else
    return c ^ d;
`endif
  endfunction

  task automatic push_frame(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  c, bt;
    logic [63:0] p;
    c  = 8'h00;
    bt = {4'hA, 1'b0, m};
    exp_q.push_back(bt);
    c = ref_chk(c, bt);
    if (m != 3'd0) begin
      p = {a, b};
      for (int i = 0; i < 8; i++) begin
        bt = p[63 - 8*i -: 8];
        exp_q.push_back(bt);
        c = ref_chk(c, bt);
      end
    end
    exp_q.push_back(c);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_start(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; mode = m; word_a = a; word_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    while (cycles < budget && !found) begin
      @(negedge clk);
      cycles++;
      if (done) found = 1'b1;
    end
  endtask

  task automatic wait_hs(input int n, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (hs_cnt < n && k < 100);
    checks++;
    if (hs_cnt < n) begin
      errors++;
      $display("FAIL %s_hs_timeout: got %0d handshakes, expected %0d", name, hs_cnt, n);
    end
  endtask

  task automatic check_end(input string name, input bit found, input int cycles, input int exp_cycles);
    checks++;
    if (!found || cycles !== exp_cycles) begin
      errors++;
      $display("FAIL %s_done: got found=%0d at cycle %0d, expected cycle %0d", name, found, cycles, exp_cycles);
    end
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after: got busy=%b valid=%b, expected 0 0", name, busy, bus.out_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_queue: got %0d bytes left, expected 0", name, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_byte, bus.out_valid, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got byte=%02h valid=%b busy=%b done=%b, expected all 0",
               bus.out_byte, bus.out_valid, busy, done);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int cyc; bit found; logic [7:0] c;
    bus.out_ready = 1'b1;
    hs_cnt = 0;
    c = 8'h00;
    foreach (exp_q[i]) c = c; // queue is empty here
    begin
      logic [7:0] fr [9];
      fr = '{8'hA1, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
      for (int i = 0; i < 9; i++) begin
        exp_q.push_back(fr[i]);
        c = ref_chk(c, fr[i]);
      end
    end
    exp_q.push_back(c);
    checks++;
`ifndef SERIALIZER_CRC8_EN
    if (c !== 8'hA1) begin
      errors++;
      $display("FAIL full_model_xor: got %02h, expected A1", c);
    end
`endif
    send_start(3'd1, 32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || busy !== 1'b1 || bus.out_byte !== 8'hA1) begin
      errors++;
      $display("FAIL full_first_cycle: got valid=%b busy=%b byte=%02h, expected 1 1 A1",
               bus.out_valid, busy, bus.out_byte);
    end
    wait_done(40, cyc, found);
    check_end("full", found, cyc + 1, 11);
    checks++;
    if (hs_cnt !== 10) begin
      errors++;
      $display("FAIL full_length: got %0d bytes, expected 10", hs_cnt);
    end
  endtask

  task automatic test_null_regime();
    int cyc; bit found;
    hs_cnt = 0;
    exp_q.push_back(8'hA0);
`ifdef SERIALIZER_CRC8_EN
    exp_q.push_back(8'h69);
`else
    exp_q.push_back(8'hA0);
`endif
    send_start(3'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done(20, cyc, found);
    check_end("null", found, cyc, 3);
    checks++;
    if (hs_cnt !== 2) begin
      errors++;
      $display("FAIL null_length: got %0d bytes, expected 2", hs_cnt);
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit found;
    hs_cnt = 0;
    push_frame(3'd3, 32'hDEAD_01EF, 32'h0BAD_F00D);
    send_start(3'd3, 32'hDEAD_01EF, 32'h0BAD_F00D);
    wait_hs(3, "bp");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h01) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b byte=%02h, expected 1 01", i, bus.out_valid, bus.out_byte);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(40, cyc, found);
    check_end("bp", found, 1, 1);
    checks++;
    if (hs_cnt !== 10) begin
      errors++;
      $display("FAIL bp_length: got %0d bytes, expected 10", hs_cnt);
    end
  endtask

  task automatic test_ignored_start();
    int cyc; bit found;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    hs_cnt = 0;
    push_frame(3'd5, a, b);
    send_start(3'd5, a, b);
    wait_hs(4, "ign");
    send_start(3'd2, ~a, ~b);
    wait_done(40, cyc, found);
    check_end("ign", found, 1, 1);
  endtask

  task automatic test_ena_low();
    int cyc; bit found;
    logic [31:0] a, b;
    logic [7:0] held;
    a = $urandom(); b = $urandom();
    hs_cnt = 0;
    push_frame(3'(1 + $urandom_range(0, 6)), a, b);
    send_start(exp_q[0][2:0], a, b);
    wait_hs(6, "ena");
    held = exp_q[0];
    @(posedge clk); #1;
    ena = 1'b0;
    // start with ena low must be ignored too
    start = 1'b1; mode = 3'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_byte !== 8'h00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ena_low_%0d: got valid=%b byte=%02h busy=%b, expected 0 00 0",
                 i, bus.out_valid, bus.out_byte, busy);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    ena = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== held) begin
      errors++;
      $display("FAIL ena_resume: got valid=%b byte=%02h, expected 1 %02h", bus.out_valid, bus.out_byte, held);
    end
    wait_done(40, cyc, found);
    check_end("ena", found, 1, 1);
  endtask

  task automatic test_reset_mid();
    int cyc, d0; bit found;
    hs_cnt = 0;
    push_frame(3'd4, 32'h1122_3344, 32'h5566_7788);
    send_start(3'd4, 32'h1122_3344, 32'h5566_7788);
    wait_hs(6, "rstmid");
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL rstmid_idle: got valid=%b busy=%b state=%0d, expected 0 0 0",
               bus.out_valid, busy, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d done pulses, expected 0", done_cnt - d0);
    end
    hs_cnt = 0;
    push_frame(3'd6, 32'hCAFE_BABE, 32'h0000_FFFF);
    send_start(3'd6, 32'hCAFE_BABE, 32'h0000_FFFF);
    wait_done(40, cyc, found);
    check_end("rstmid_fresh", found, cyc, 11);
  endtask

  task automatic test_back_to_back();
    int cyc; bit found;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    hs_cnt = 0;
    push_frame(3'd7, a, b);
    send_start(3'd7, a, b);            // start in N, now in N+1
    repeat (10) @(posedge clk); #1;    // now in N+11
    push_frame(3'd2, b, a);
    start = 1'b1; mode = 3'd2; word_a = b; word_b = a;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got done=%b busy=%b, expected 1 0", done, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hA2) begin
      errors++;
      $display("FAIL b2b_header: got valid=%b byte=%02h, expected 1 A2", bus.out_valid, bus.out_byte);
    end
    wait_done(40, cyc, found);
    check_end("b2b", found, cyc + 1, 11);
    checks++;
    if (hs_cnt !== 20) begin
      errors++;
      $display("FAIL b2b_length: got %0d bytes, expected 20", hs_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_null_regime();
    test_backpressure();
    test_ignored_start();
    test_ena_low();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
